// File: rtl/div16x8_if.sv
// div16x8_if: operand/result/status bundle for div16x8; master drives start and operands, slave returns results, flags and segments.
interface div16x8_if;
  logic        start;
  logic [15:0] dividend;
  logic [7:0]  divisor;
  logic [15:0] quotient;
  logic [7:0]  remainder;
  logic        done_flag;
  logic        busy;
  logic        div_by_zero;
  logic [2:0]  state_out;
  logic        seg_a, seg_b, seg_c, seg_d, seg_e, seg_f, seg_g;
  modport master (
    output start, dividend, divisor,
    input  quotient, remainder, done_flag, busy, div_by_zero, state_out,
    input  seg_a, seg_b, seg_c, seg_d, seg_e, seg_f, seg_g
  );
  modport slave (
    input  start, dividend, divisor,
    output quotient, remainder, done_flag, busy, div_by_zero, state_out,
    output seg_a, seg_b, seg_c, seg_d, seg_e, seg_f, seg_g
  );
endinterface

// File: rtl/div16x8.sv
// div16x8: sequential unsigned 16/8 restoring divider, one quotient bit per clock, with start/done status and seven-segment state display.
// Ports: clk, reset_a (async active-high), bus (div16x8_if.slave: start, dividend, divisor in; quotient, remainder, done_flag, busy, div_by_zero, state_out, seg_a..seg_g out).
// Optional: define DIV_EARLY_EXIT_EN to finish after a single cycle when dividend < divisor.
module div16x8 (
  input logic clk,
  input logic reset_a,
  div16x8_if.slave bus
);
  typedef enum logic [2:0] {IDLE = 3'd0, CALC = 3'd1, DONE = 3'd2, ERR = 3'd3} state_t;
  state_t      state, nxt;
  logic [7:0]  r;
  logic [15:0] q;
  logic [7:0]  dvs;
  logic [3:0]  cnt;
  logic        fast;
  logic [15:0] quotient;
  logic [7:0]  remainder;
  logic        done_flag, busy, div_by_zero;
  logic [6:0]  seg, seg_n;
  logic [8:0]  sh;
  logic        ge, acc, early;
  logic [7:0]  nr;
  always_comb begin
    // The partial remainder is always below the divisor, so 8 stored bits suffice; the shifted value needs 9.
    sh = {r, q[15]};
    ge = sh >= {1'b0, dvs};
    nr = ge ? 8'(sh - {1'b0, dvs}) : sh[7:0];
    acc = bus.start && (state == IDLE || state == DONE || state == ERR);
`ifdef DIV_EARLY_EXIT_EN
    early = bus.dividend < {8'h00, bus.divisor};
`else
    early = 1'b0;
`endif
    nxt = state == CALC ? ((fast || cnt == 4'd15) ? DONE : CALC) :
          !(state == IDLE || state == DONE || state == ERR) ? IDLE :
          !acc ? state :
          bus.divisor == 8'd0 ? ERR : CALC;
    seg_n = nxt == CALC ? 7'b0110000 :
            nxt == DONE ? 7'b1101101 :
            nxt == ERR  ? 7'b1001111 : 7'b1111110;
  end
  always_ff @(posedge clk or posedge reset_a) begin
    if (reset_a) begin
      state       <= IDLE;
      r           <= '0;
      q           <= '0;
      dvs         <= '0;
      cnt         <= '0;
      fast        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      done_flag   <= 1'b0;
      busy        <= 1'b0;
      div_by_zero <= 1'b0;
      seg         <= 7'b1111110;
    end else begin
      state       <= nxt;
      busy        <= nxt == CALC;
      done_flag   <= nxt == DONE;
      div_by_zero <= nxt == ERR;
      seg         <= seg_n;
      if (state == CALC) begin
        r   <= nr;
        q   <= {q[14:0], ge};
        cnt <= cnt + 4'd1;
        // A short division (dividend < divisor) has quotient 0 and the dividend itself as remainder.
        if (fast) begin
          quotient  <= '0;
          remainder <= q[7:0];
        end else if (cnt == 4'd15) begin
          quotient  <= {q[14:0], ge};
          remainder <= nr;
        end
      end else if (acc && bus.divisor == 8'd0) begin
        quotient  <= 16'hFFFF;
        remainder <= '0;
      end else if (acc) begin
        dvs  <= bus.divisor;
        r    <= '0;
        q    <= bus.dividend;
        cnt  <= '0;
        fast <= early;
      end
    end
  end
  assign bus.quotient    = quotient;
  assign bus.remainder   = remainder;
  assign bus.done_flag   = done_flag;
  assign bus.busy        = busy;
  assign bus.div_by_zero = div_by_zero;
  assign bus.state_out   = state;
  assign {bus.seg_a, bus.seg_b, bus.seg_c, bus.seg_d, bus.seg_e, bus.seg_f, bus.seg_g} = seg;
endmodule

// File: tb/tb_div16x8.sv
// tb_div16x8: directed-vector self-checking bench for div16x8.
module tb_div16x8;
  logic clk = 1'b0;
  logic reset_a;
  int errors = 0;
  int checks = 0;
  int n;
  div16x8_if bus ();
  div16x8 dut (.clk(clk), .reset_a(reset_a), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic launch(input logic [15:0] a, input logic [7:0] b);
    bus.dividend = a;
    bus.divisor  = b;
    bus.start    = 1'b1;
    tick();
    bus.start    = 1'b0;
  endtask
  task automatic run_to_done(output int cnt);
    cnt = 0;
    while (!bus.done_flag && cnt < 40) begin
      tick();
      cnt++;
    end
  endtask
  function automatic logic [6:0] segs();
    return {bus.seg_a, bus.seg_b, bus.seg_c, bus.seg_d, bus.seg_e, bus.seg_f, bus.seg_g};
  endfunction
  initial begin
    reset_a = 1'b1;
    bus.start = 1'b0;
    bus.dividend = '0;
    bus.divisor = '0;
    repeat (2) tick();
    check("rst_state", bus.state_out, 0);
    check("rst_q", bus.quotient, 0);
    check("rst_r", bus.remainder, 0);
    check("rst_flags", {bus.done_flag, bus.busy, bus.div_by_zero}, 0);
    check("rst_seg", segs(), 7'b1111110);
    reset_a = 1'b0;
    tick();
    launch(16'd1000, 8'd7);
    check("calc_busy", bus.busy, 1);
    check("calc_state", bus.state_out, 1);
    check("calc_seg", segs(), 7'b0110000);
    repeat (15) tick();
    check("e15_busy", bus.busy, 1);
    check("e15_done", bus.done_flag, 0);
    tick();
    check("e16_done", bus.done_flag, 1);
    check("e16_busy", bus.busy, 0);
    check("1000_7_q", bus.quotient, 142);
    check("1000_7_r", bus.remainder, 6);
    check("done_state", bus.state_out, 2);
    check("done_seg", segs(), 7'b1101101);
    repeat (3) tick();
    check("done_hold", {bus.done_flag, bus.quotient}, {1'b1, 16'd142});
    launch(16'hFFFF, 8'h01);
    check("q_held_calc", bus.quotient, 142);
    run_to_done(n);
    check("ffff_1_lat", n, 16);
    check("ffff_1_q", bus.quotient, 16'hFFFF);
    check("ffff_1_r", bus.remainder, 0);
    launch(16'hFFFF, 8'hFF);
    run_to_done(n);
    check("ffff_ff_q", bus.quotient, 16'h0101);
    check("ffff_ff_r", bus.remainder, 0);
    launch(16'h1234, 8'h00);
    check("err_state", bus.state_out, 3);
    check("err_dbz", bus.div_by_zero, 1);
    check("err_q", bus.quotient, 16'hFFFF);
    check("err_r", bus.remainder, 0);
    check("err_seg", segs(), 7'b1001111);
    repeat (3) tick();
    check("err_hold", {bus.state_out, bus.div_by_zero}, {3'd3, 1'b1});
    launch(16'd100, 8'd10);
    check("err_exit_dbz", bus.div_by_zero, 0);
    check("err_exit_busy", bus.busy, 1);
    run_to_done(n);
    check("100_10_lat", n, 16);
    check("100_10_q", bus.quotient, 10);
    check("100_10_r", bus.remainder, 0);
    launch(16'd50000, 8'd3);
    repeat (5) tick();
    bus.dividend = 16'd9;
    bus.divisor  = 8'd9;
    bus.start    = 1'b1;
    tick();
    bus.start    = 1'b0;
    check("ign_busy", bus.busy, 1);
    run_to_done(n);
    check("ign_lat", n, 10);
    check("50000_3_q", bus.quotient, 16666);
    check("50000_3_r", bus.remainder, 2);
    launch(16'd40000, 8'd201);
    repeat (8) tick();
    #2 reset_a = 1'b1;
    #1;
    check("abort_state", bus.state_out, 0);
    check("abort_busy", bus.busy, 0);
    check("abort_q", bus.quotient, 0);
    check("abort_r", bus.remainder, 0);
    #2 reset_a = 1'b0;
    tick();
    launch(16'd40000, 8'd201);
    run_to_done(n);
    check("40000_201_lat", n, 16);
    check("40000_201_q", bus.quotient, 199);
    check("40000_201_r", bus.remainder, 1);
    launch(16'd5, 8'd200);
    run_to_done(n);
`ifdef DIV_EARLY_EXIT_EN
    check("5_200_lat", n, 1);
`else
    check("5_200_lat", n, 16);
`endif
    check("5_200_q", bus.quotient, 0);
    check("5_200_r", bus.remainder, 5);
    bus.dividend = 16'd300;
    bus.divisor  = 8'd7;
    bus.start    = 1'b1;
    tick();
    check("held_start_busy", bus.busy, 1);
    run_to_done(n);
    check("held_q", bus.quotient, 42);
    check("held_r", bus.remainder, 6);
    tick();
    check("relaunch_busy", bus.busy, 1);
    bus.start = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
